// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared state, source-select and orientation constants for the AES round datapath
package aes_pkg;
    localparam int NR_DEFAULT = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ARK,
        ST_SUB,
        ST_SHIFT,
        ST_MIX,
        ST_OUT
    } aes_state_t;

    localparam logic [2:0] SRC_LOAD  = 3'd0;
    localparam logic [2:0] SRC_SUB   = 3'd1;
    localparam logic [2:0] SRC_SHIFT = 3'd2;
    localparam logic [2:0] SRC_MIX   = 3'd3;
    localparam logic [2:0] SRC_ARK   = 3'd4;

    localparam logic ROW = 1'b0;
    localparam logic COL = 1'b1;
endpackage

// File: rtl/aes_word_step.sv
// rtl/aes_word_step.sv - per-phase word index counter with qualifier gating and last-word detect
module aes_word_step (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       active,
    input  logic       qual,
    input  logic       wrap_to_one,
    output logic [1:0] idx,
    output logic       last
);
    assign last = (idx == 2'd3);

    // Leaving SUB wraps to 1 because ShiftRows never touches row 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx <= 2'd0;
        end else if (!active) begin
            idx <= 2'd0;
        end else if (qual) begin
            idx <= (last && wrap_to_one) ? 2'd1 : idx + 2'd1;
        end
    end
endmodule

// File: rtl/aes_round_seq.sv
// rtl/aes_round_seq.sv - AES-128 encrypt round sequencer driving the state-matrix controls
module aes_round_seq
    import aes_pkg::*;
#(
    parameter int NR = NR_DEFAULT,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          rk_req,
    output logic [RW-1:0] rk_round,
    output logic [1:0]    rk_col,
    input  logic          rk_valid,
    output logic [1:0]    mat_in_idx,
    output logic          mat_in_row_col,
    output logic          mat_we,
    output logic [1:0]    mat_out_idx,
    output logic          mat_out_row_col,
    output logic [2:0]    src_sel,
    output logic [1:0]    shift_amt,
    output logic [RW-1:0] round
);
    aes_state_t    state_q, state_d;
    logic [RW-1:0] round_q;
    logic [1:0]    idx;
    logic          last;
    logic          qual;
    logic          writes;
    logic          row_col;

    aes_word_step u_step (
        .clk         (clk),
        .reset_n     (reset_n),
        .active      (state_q != ST_IDLE),
        .qual        (qual),
        .wrap_to_one (state_q == ST_SUB),
        .idx         (idx),
        .last        (last)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The round advances only on ARK -> SUB, so the final ARK keeps round = NR.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            round_q <= '0;
        end else if (state_q == ST_IDLE && start) begin
            round_q <= '0;
        end else if (state_q == ST_ARK && rk_valid && last && round_q != RW'(NR)) begin
            round_q <= round_q + 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        qual      = 1'b0;
        writes    = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        rk_req    = 1'b0;
        done      = 1'b0;
        row_col   = ROW;
        src_sel   = SRC_LOAD;
        shift_amt = 2'd0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                in_ready = 1'b1;
                row_col  = COL;
                qual     = in_valid;
                writes   = 1'b1;
                if (qual && last) state_d = ST_ARK;
            end
            ST_ARK: begin
                rk_req  = 1'b1;
                row_col = COL;
                src_sel = SRC_ARK;
                qual    = rk_valid;
                writes  = 1'b1;
                if (qual && last) state_d = (round_q == RW'(NR)) ? ST_OUT : ST_SUB;
            end
            ST_SUB: begin
                row_col = COL;
                src_sel = SRC_SUB;
                qual    = 1'b1;
                writes  = 1'b1;
                if (last) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                row_col   = ROW;
                src_sel   = SRC_SHIFT;
                shift_amt = idx;
                qual      = 1'b1;
                writes    = 1'b1;
                if (last) state_d = (round_q < RW'(NR)) ? ST_MIX : ST_ARK;
            end
            ST_MIX: begin
                row_col = COL;
                src_sel = SRC_MIX;
                qual    = 1'b1;
                writes  = 1'b1;
                if (last) state_d = ST_ARK;
            end
            ST_OUT: begin
                out_valid = 1'b1;
                row_col   = COL;
                qual      = out_ready;
                done      = out_ready && last;
                if (qual && last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy            = (state_q != ST_IDLE);
    assign mat_we          = writes && qual;
    assign mat_in_idx      = idx;
    assign mat_out_idx     = idx;
    assign mat_in_row_col  = row_col;
    assign mat_out_row_col = row_col;
    assign rk_round        = (state_q == ST_ARK) ? round_q : '0;
    assign rk_col          = (state_q == ST_ARK) ? idx : 2'd0;
    assign round           = round_q;
endmodule

// File: tb/tb_aes_round_seq.sv
// tb/tb_aes_round_seq.sv - directed bench for aes_round_seq with an AES-128 datapath model around it
module tb_aes_round_seq;
    import aes_pkg::*;

    localparam int NR = 10;
    localparam int RW = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic          busy;
    logic          done;
    logic          in_valid;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic          rk_req;
    logic [RW-1:0] rk_round;
    logic [1:0]    rk_col;
    logic          rk_valid;
    logic [1:0]    mat_in_idx;
    logic          mat_in_row_col;
    logic          mat_we;
    logic [1:0]    mat_out_idx;
    logic          mat_out_row_col;
    logic [2:0]    src_sel;
    logic [1:0]    shift_amt;
    logic [RW-1:0] round;

    always #5 clk = ~clk;

    aes_round_seq #(.NR(NR), .RW(RW)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .busy            (busy),
        .done            (done),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .rk_req          (rk_req),
        .rk_round        (rk_round),
        .rk_col          (rk_col),
        .rk_valid        (rk_valid),
        .mat_in_idx      (mat_in_idx),
        .mat_in_row_col  (mat_in_row_col),
        .mat_we          (mat_we),
        .mat_out_idx     (mat_out_idx),
        .mat_out_row_col (mat_out_row_col),
        .src_sel         (src_sel),
        .shift_amt       (shift_amt),
        .round           (round)
    );

    logic [26:0] all_outs;
    assign all_outs = {busy, done, in_ready, out_valid, rk_req, rk_round, rk_col, mat_in_idx,
                       mat_in_row_col, mat_we, mat_out_idx, mat_out_row_col, src_sel, shift_amt, round};

    logic [7:0]  sbt [256];
    logic [31:0] w   [44];
    logic [31:0] pt  [4];
    logic [31:0] ct  [4];
    logic [7:0]  m   [4][4];
    logic [31:0] rd_w, wr_w;

    logic        stat_clr;
    int          load_wr, load_bad, shift_wr, shift_bad;
    logic [2:0]  seq_q [$];
    logic [2:0]  exp_seq [$];
    logic [31:0] out_q [$];

    int n_cmp = 0;
    int n_mis = 0;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [31:0] mix(input logic [31:0] c);
        logic [7:0] a0 = c[31:24], a1 = c[23:16], a2 = c[15:8], a3 = c[7:0];
        return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    endfunction

    function automatic logic [31:0] rotl(input logic [31:0] x, input logic [1:0] n);
        case (n)
            2'd1:    return {x[23:0], x[31:24]};
            2'd2:    return {x[15:0], x[31:16]};
            2'd3:    return {x[7:0],  x[31:8]};
            default: return x;
        endcase
    endfunction

    // Environment datapath: combinational read, transform, write back on the edge.
    always_comb begin
        rd_w = mat_out_row_col ?
               {m[0][mat_out_idx], m[1][mat_out_idx], m[2][mat_out_idx], m[3][mat_out_idx]} :
               {m[mat_out_idx][0], m[mat_out_idx][1], m[mat_out_idx][2], m[mat_out_idx][3]};
        case (src_sel)
            SRC_LOAD:  wr_w = pt[mat_in_idx];
            SRC_SUB:   wr_w = {sbt[rd_w[31:24]], sbt[rd_w[23:16]], sbt[rd_w[15:8]], sbt[rd_w[7:0]]};
            SRC_SHIFT: wr_w = rotl(rd_w, shift_amt);
            SRC_MIX:   wr_w = mix(rd_w);
            SRC_ARK:   wr_w = rd_w ^ w[{rk_round, rk_col}];
            default:   wr_w = rd_w;
        endcase
    end

    always @(posedge clk) begin
        if (mat_we) begin
            for (int k = 0; k < 4; k++) begin
                if (mat_in_row_col) m[k][mat_in_idx] <= wr_w[31-8*k -: 8];
                else                m[mat_in_idx][k] <= wr_w[31-8*k -: 8];
            end
        end
        if (stat_clr) begin
            load_wr   <= 0;
            load_bad  <= 0;
            shift_wr  <= 0;
            shift_bad <= 0;
            seq_q.delete();
            out_q.delete();
        end else begin
            if (mat_we) begin
                seq_q.push_back(src_sel);
                if (src_sel == SRC_LOAD) begin
                    load_wr <= load_wr + 1;
                    if (mat_in_row_col !== COL) load_bad <= load_bad + 1;
                end
                if (src_sel == SRC_SHIFT) begin
                    shift_wr <= shift_wr + 1;
                    if (mat_in_row_col !== ROW || mat_in_idx == 2'd0 || shift_amt !== mat_in_idx)
                        shift_bad <= shift_bad + 1;
                end
            end
            if (out_valid && out_ready) out_q.push_back(rd_w);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_ct(input string tag);
        chk({tag, "_ct_count"}, 64'(out_q.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("%s_ct%0d", tag, i), (i < out_q.size()) ? out_q[i] : 32'h0, ct[i]);
    endtask

    task automatic check_seq(input string tag);
        int bad = 0;
        if (seq_q.size() != exp_seq.size()) bad = 1000;
        else for (int i = 0; i < seq_q.size(); i++) if (seq_q[i] !== exp_seq[i]) bad++;
        chk({tag, "_src_seq"}, 64'(bad), 64'd0);
    endtask

    task automatic kick(input logic hold);
        @(negedge clk);
        start    = 1'b1;
        stat_clr = 1'b1;
        @(negedge clk);
        start    = hold;
        stat_clr = 1'b0;
        chk("first_in_ready", {busy, in_ready}, 2'b11);
    endtask

    // Runs from the first LOAD negedge until IDLE; mode selects the directed disturbance.
    task automatic run_block(input int mode, output int bc, output int nd);
        bit fin = 0, kdone = 0, odone = 0;
        int ks = 0, os = 0;
        bc = 0;
        nd = 0;
        for (int i = 0; i < 1000; i++) begin
            if (!busy) begin
                fin = 1;
                break;
            end
            bc++;
            if (done) nd++;
            if (mode == 1) begin
                if (ks > 0) begin
                    ks--;
                    if (ks == 0) rk_valid = 1'b1;
                end
                if (!kdone && rk_req && rk_round == 4'd3 && rk_col == 2'd2) begin
                    kdone = 1;
                    ks = 5;
                    rk_valid = 1'b0;
                end
                if (ks > 0) begin
                    #1;
                    chk("kstall_we", mat_we, 1'b0);
                    chk("kstall_hold", {rk_req, rk_round, rk_col, mat_in_idx, mat_in_row_col}, {1'b1, 4'd3, 2'd2, 2'd2, 1'b1});
                end
            end
            if (mode == 2) begin
                if (in_ready) in_valid = ~in_valid;
                else in_valid = 1'b1;
                if (os > 0) begin
                    os--;
                    if (os == 0) out_ready = 1'b1;
                end
                if (!odone && out_valid && mat_out_idx == 2'd1) begin
                    odone = 1;
                    os = 3;
                    out_ready = 1'b0;
                end
                if (os > 0) begin
                    #1;
                    chk("ostall_hold", {out_valid, mat_out_idx, mat_out_row_col, done}, {1'b1, 2'd1, 1'b1, 1'b0});
                end
            end
            if (mode == 3) start = (bc == 50);
            if (mode == 4 && src_sel == SRC_MIX && round == 4'd5) begin
                reset_n = 1'b0;
                #1;
                chk("midrst_outs", all_outs, 27'd0);
            end
            @(negedge clk);
        end
        if (!fin) chk("run_timeout", 1'b0, 1'b1);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        rk_valid  = 1'b1;
    endtask

    initial begin
        int bc, nd;
        logic [7:0] inv, rcon;
        logic [31:0] t;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h01;
            if (x == 0) inv = 8'h00;
            else for (int k = 0; k < 254; k++) inv = gm(inv, 8'(x));
            sbt[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
        w[0] = 32'h2b7e1516; w[1] = 32'h28aed2a6; w[2] = 32'habf71588; w[3] = 32'h09cf4f3c;
        rcon = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = rotl(t, 2'd1);
                t = {sbt[t[31:24]], sbt[t[23:16]], sbt[t[15:8]], sbt[t[7:0]]} ^ {rcon, 24'h0};
                rcon = xt(rcon);
            end
            w[i] = w[i-4] ^ t;
        end
        pt[0] = 32'h3243f6a8; pt[1] = 32'h885a308d; pt[2] = 32'h313198a2; pt[3] = 32'he0370734;
        ct[0] = 32'h3925841d; ct[1] = 32'h02dc09fb; ct[2] = 32'hdc118597; ct[3] = 32'h196a0b32;
        repeat (4) exp_seq.push_back(SRC_LOAD);
        repeat (4) exp_seq.push_back(SRC_ARK);
        for (int r = 1; r <= NR; r++) begin
            repeat (4) exp_seq.push_back(SRC_SUB);
            repeat (3) exp_seq.push_back(SRC_SHIFT);
            if (r < NR) repeat (4) exp_seq.push_back(SRC_MIX);
            repeat (4) exp_seq.push_back(SRC_ARK);
        end

        reset_n = 1'b0; start = 1'b0; stat_clr = 1'b1;
        in_valid = 1'b1; out_ready = 1'b1; rk_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outs", all_outs, 27'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", all_outs, 27'd0);

        kick(1'b0);
        run_block(0, bc, nd);
        chk("plain_busy", 64'(bc), 64'd158);
        chk("plain_done", 64'(nd), 64'd1);
        chk("plain_shift_wr", 64'(shift_wr), 64'd30);
        chk("plain_shift_bad", 64'(shift_bad), 64'd0);
        chk("plain_round_end", round, 4'd10);
        check_ct("plain");
        check_seq("plain");

        kick(1'b0);
        run_block(1, bc, nd);
        chk("kstall_busy", 64'(bc), 64'd163);
        check_ct("kstall");
        check_seq("kstall");

        in_valid = 1'b0;
        kick(1'b0);
        run_block(2, bc, nd);
        chk("bp_load_wr", 64'(load_wr), 64'd4);
        chk("bp_load_bad", 64'(load_bad), 64'd0);
        chk("bp_done", 64'(nd), 64'd1);
        check_ct("bp");

        kick(1'b0);
        run_block(3, bc, nd);
        chk("busy_start_busy", 64'(bc), 64'd158);
        chk("busy_start_done", 64'(nd), 64'd1);
        check_ct("busy_start");

        kick(1'b1);
        run_block(0, bc, nd);
        chk("b2b_first_busy", 64'(bc), 64'd158);
        chk("b2b_idle_gap", {busy, in_ready}, 2'b00);
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        start = 1'b0;
        chk("b2b_reenter", {busy, in_ready, src_sel}, {1'b1, 1'b1, SRC_LOAD});
        run_block(0, bc, nd);
        chk("b2b_second_busy", 64'(bc), 64'd158);
        check_ct("b2b");

        kick(1'b0);
        run_block(4, bc, nd);
        chk("midrst_done", 64'(nd), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("midrst_idle", all_outs, 27'd0);
        kick(1'b0);
        run_block(0, bc, nd);
        chk("after_rst_busy", 64'(bc), 64'd158);
        check_ct("after_rst");
        check_seq("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
